// File: rtl/debug_pkg.sv
// Shared constants for the debug view mux and the debug word loader.
// Both sides must agree on register count and widths.
package debug_pkg;

  localparam int DBG_NUM_REGS = 7;
  localparam int DBG_DATA_W   = 32;
  localparam int DBG_HALF_W   = 16;
  localparam int DBG_SEL_W    = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HIGH   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/debug_reg_bank.sv
// Bank of debug registers written one word at a time; all entries are
// exposed in parallel as the sources read back by the debug view mux.
module debug_reg_bank
  import debug_pkg::*;
#(
  parameter int DATA_W   = DBG_DATA_W,
  parameter int NUM_REGS = DBG_NUM_REGS,
  parameter int SEL_W    = DBG_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SEL_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: only the addressed entry changes on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && (waddr == SEL_W'(i))) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  assign out1 = regs_q[0];
  assign out2 = regs_q[1];
  assign out3 = regs_q[2];
  assign out4 = regs_q[3];
  assign out5 = regs_q[4];
  assign out6 = regs_q[5];
  assign out7 = regs_q[6];

endmodule

// File: rtl/debug_word_loader.sv
// Assembles two half-words from a valid/ready channel into one debug
// register write; bad indices and select mismatches raise a one-cycle err.
module debug_word_loader
  import debug_pkg::*;
#(
  parameter int DATA_W   = DBG_DATA_W,
  parameter int HALF_W   = DBG_HALF_W,
  parameter int NUM_REGS = DBG_NUM_REGS,
  parameter int SEL_W    = DBG_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_abort,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic              wr_done,
  output logic              err
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic [HALF_W-1:0] hi_q, hi_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              xfer_s;
  logic              we_s;

  // Abort blocks acceptance so a half-word offered alongside it is never consumed.
  assign in_ready = (state_q != ST_COMMIT) && !in_abort;
  assign xfer_s   = in_valid && in_ready;

  // Next-state logic for the half-word assembly FSM.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          if (in_sel <= LAST_IDX) begin
            lo_d    = in_data;
            sel_d   = in_sel;
            state_d = ST_HIGH;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (in_abort) begin
          state_d = ST_IDLE;
        end else if (xfer_s) begin
          if (in_sel == sel_q) begin
            hi_d    = in_data;
            state_d = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_COMMIT: begin
        we_s    = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched halves and registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign wr_done = done_q;
  assign err     = err_q;

  debug_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (sel_q),
    .wdata ({hi_q, lo_q}),
    .out1  (out1),
    .out2  (out2),
    .out3  (out3),
    .out4  (out4),
    .out5  (out5),
    .out6  (out6),
    .out7  (out7)
  );

endmodule

// File: tb/tb_debug_word_loader.sv
// Bench for debug_word_loader: scenario tasks plus a scoreboard of expected
// wr_done/err events checked against the outputs when each pulse appears.
module tb_debug_word_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_abort;
  logic [31:0] outs [7];
  logic        wr_done;
  logic        err;

  typedef struct {
    bit          is_err;
    int          idx;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q [$];
  logic [31:0] model_regs [7];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          last_xfer_cyc = 0;

  debug_word_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_abort (in_abort),
    .out1     (outs[0]),
    .out2     (outs[1]),
    .out3     (outs[2]),
    .out4     (outs[3]),
    .out5     (outs[4]),
    .out6     (outs[5]),
    .out7     (outs[6]),
    .wr_done  (wr_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    ev_t ev;
    if (!rst) begin
      if (wr_done && err) begin
        tests_run++;
        tests_failed++;
        $display("FAIL pulse_overlap wr_done=%0b err=%0b required not both high", wr_done, err);
      end
      if (wr_done || err) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_event wr_done=%0b err=%0b required no event", wr_done, err);
        end else begin
          ev = exp_q.pop_front();
          if (ev.is_err) begin
            if (err !== 1'b1) begin
              tests_failed++;
              $display("FAIL sb_err got wr_done=%0b err=%0b required err", wr_done, err);
            end
          end else if (wr_done !== 1'b1 || outs[ev.idx] !== ev.data) begin
            tests_failed++;
            $display("FAIL sb_write reg%0d got %h (wr_done=%0b) required %h", ev.idx, outs[ev.idx], wr_done, ev.data);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offers one half-word from a negedge and returns at the negedge after the transfer.
  task automatic send_half(input logic [15:0] d, input logic [2:0] s);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    #1;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout in_ready=%0b required 1 within 8 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    last_xfer_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] lo, input logic [15:0] hi, input int idx);
    ev_t ev;
    send_half(lo, 3'(idx));
    ev.is_err = 1'b0;
    ev.idx    = idx;
    ev.data   = {hi, lo};
    exp_q.push_back(ev);
    model_regs[idx] = {hi, lo};
    send_half(hi, 3'(idx));
  endtask

  task automatic push_err();
    ev_t ev;
    ev.is_err = 1'b1;
    ev.idx    = 0;
    ev.data   = 32'h0;
    exp_q.push_back(ev);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (outs[i] !== model_regs[i]) begin
        tests_failed++;
        $display("FAIL %s_out%0d got %h required %h", tag, i + 1, outs[i], model_regs[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0;
    in_sel = 3'd0;
    in_abort = 1'b0;
    for (int i = 0; i < 7; i++) model_regs[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_regs("reset");
    tests_run++;
    if (wr_done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_flags got wr_done=%0b err=%0b in_ready=%0b required 0 0 1", wr_done, err, in_ready);
    end
  endtask

  task automatic test_basic_write();
    send_word(16'hBEEF, 16'hDEAD, 2);
    tests_run++;
    if (in_ready !== 1'b0 || wr_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_cycle got in_ready=%0b wr_done=%0b required 0 0", in_ready, wr_done);
    end
    @(negedge clk);
    tests_run++;
    if (wr_done !== 1'b1 || outs[2] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_latency got wr_done=%0b out3=%h required 1 deadbeef", wr_done, outs[2]);
    end
    @(negedge clk);
    tests_run++;
    if (wr_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_width got wr_done=%0b required 0", wr_done);
    end
    check_regs("basic");
  endtask

  task automatic test_bad_index();
    push_err();
    send_half(16'h1234, 3'd7);
    tests_run++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_index got err=%0b in_ready=%0b required 1 1", err, in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_width got err=%0b required 0", err);
    end
    send_word(16'h0001, 16'h0002, 0);
    idle(2);
    check_regs("badidx");
  endtask

  task automatic test_mismatch();
    send_half(16'hAAAA, 3'd1);
    push_err();
    send_half(16'h5555, 3'd4);
    tests_run++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mismatch got err=%0b in_ready=%0b required 1 1", err, in_ready);
    end
    send_word(16'h0F0F, 16'hF0F0, 4);
    idle(2);
    check_regs("mismatch");
  endtask

  task automatic test_abort();
    send_half(16'h1111, 3'd5);
    in_abort = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h9999;
    in_sel   = 3'd5;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ready got in_ready=%0b required 0", in_ready);
    end
    @(negedge clk);
    in_abort = 1'b0;
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (err !== 1'b0 || wr_done !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_flags got err=%0b wr_done=%0b in_ready=%0b required 0 0 1", err, wr_done, in_ready);
    end
    send_word(16'h2222, 16'h3333, 5);
    idle(2);
    check_regs("abort");
  endtask

  task automatic test_reset_midword();
    send_half(16'h1111, 3'd5);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) model_regs[i] = 32'h0;
    idle(3);
    tests_run++;
    if (wr_done !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_midword got wr_done=%0b in_ready=%0b required 0 1", wr_done, in_ready);
    end
    check_regs("rstmid");
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    send_half(16'h4444, 3'd0);
    first_cyc = last_xfer_cyc;
    exp_q.push_back('{1'b0, 0, 32'h55554444});
    model_regs[0] = 32'h55554444;
    send_half(16'h5555, 3'd0);
    send_word(16'h6666, 16'h7777, 6);
    tests_run++;
    if (last_xfer_cyc - first_cyc !== 4) begin
      tests_failed++;
      $display("FAIL throughput got %0d cycles for two words' halves required 4", last_xfer_cyc - first_cyc);
    end
    idle(3);
    check_regs("b2b");
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bad_index();
    test_mismatch();
    test_abort();
    test_reset_midword();
    test_back_to_back();
    idle(3);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain got %0d pending events required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
